// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the shifter datapath: operation encodings,
// the sequential shifter's FSM state type and the op enum.
package shifter_pkg;

    // Operation encodings shared with the combinational shifters
    localparam logic [1:0] ENC_SLL = 2'd0;
    localparam logic [1:0] ENC_SRL = 2'd1;
    localparam logic [1:0] ENC_SRA = 2'd2;
    localparam logic [1:0] ENC_ROR = 2'd3;

    typedef enum logic [1:0] {
        SLL = ENC_SLL,
        SRL = ENC_SRL,
        SRA = ENC_SRA,
        ROR = ENC_ROR
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle for seq_shifter. The master drives the request
// (start, a, amt, op); the slave returns busy, done and y.
interface seq_shifter_if
    import shifter_pkg::*;
#(
    parameter int N         = 32,
    parameter int AMT_WIDTH = $clog2(N)
) ();

    logic                 start;
    logic [N-1:0]         a;
    logic [AMT_WIDTH-1:0] amt;
    shift_op_t            op;
    logic                 busy;
    logic                 done;
    logic [N-1:0]         y;

    modport master (
        output start, a, amt, op,
        input  busy, done, y
    );

    modport slave (
        input  start, a, amt, op,
        output busy, done, y
    );

endinterface

// File: rtl/seq_shifter_shift1.sv
// shift1_stage: combinational single-bit shift of an N-bit word.
// Rotate right is only built when SEQ_SHIFTER_ROTATE_EN is defined;
// otherwise op=ROR falls through to the logical right shift.
module shift1_stage
    import shifter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] din,
    input  shift_op_t    op,
    output logic [N-1:0] dout
);

    // Select the one-bit shift for the latched operation
    always_comb begin
        dout = {1'b0, din[N-1:1]};
        case (op)
            SLL:     dout = {din[N-2:0], 1'b0};
            SRL:     dout = {1'b0, din[N-1:1]};
            SRA:     dout = {din[N-1], din[N-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
            ROR:     dout = {din[0], din[N-1:1]};
`endif
            default: dout = {1'b0, din[N-1:1]};
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: iterative shifter applying one bit of shift per clock.
// A request is accepted only in IDLE; y is written when entering DONE
// and done pulses for exactly that one cycle.
// Optional feature macro: SEQ_SHIFTER_ROTATE_EN (enables op=ROR).
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int N         = 32,
    parameter int AMT_WIDTH = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_shifter_if.slave  bus
);

    localparam logic [AMT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [AMT_WIDTH-1:0] CNT_ONE  = {{(AMT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [N-1:0]         work;
    logic [N-1:0]         shifted;
    logic [AMT_WIDTH-1:0] cnt;
    shift_op_t            op_q;
    logic [N-1:0]         y_q;
    logic                 busy_q;
    logic                 done_q;

    shift1_stage #(.N(N)) u_stage (
        .din  (work),
        .op   (op_q),
        .dout (shifted)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;

    // Control FSM, shift counter and result register; the final shift
    // goes straight into y so the result appears on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= CNT_ZERO;
            op_q   <= SLL;
            y_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work   <= bus.a;
                        cnt    <= bus.amt;
                        op_q   <= bus.op;
                        busy_q <= 1'b1;
                        if (bus.amt == CNT_ZERO) begin
                            y_q    <= bus.a;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        y_q    <= shifted;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (N=32).
// Expected ROR result follows SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;
    import shifter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_shifter_if #(.N(32)) bus ();

    seq_shifter #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int cycle_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int done_cycle = 0;
    logic [31:0] done_y = '0;

    int accept_cycle = 0;
    int busy_base = 0;
    int done_base = 0;

`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam logic [31:0] ROR_EXP = 32'h0000_0034;
`else
    localparam logic [31:0] ROR_EXP = 32'h0000_0000;
`endif

    // Post-edge monitor: counts edges, busy samples and done pulses
    always @(posedge clk) begin
        #1;
        cycle_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cycle = cycle_cnt;
            done_y = bus.y;
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [4:0] amt, input shift_op_t op);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.amt = amt;
        bus.op = op;
        busy_base = busy_cnt;
        done_base = done_cnt;
        @(posedge clk);
        #2;
        accept_cycle = cycle_cnt;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > done_base) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
        end
        checks++;
        if (bus.y !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_y: got %h expected 00000000", bus.y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sll();
        start_op(32'h0000_001A, 5'd3, SLL);
        wait_done(40);
        @(negedge clk);
        checks++;
        if (done_y !== 32'h0000_00D0) begin
            failures++;
            $display("[TB] FAIL sll_y: got %h expected 000000d0", done_y);
        end
        checks++;
        if (done_cycle - accept_cycle !== 3) begin
            failures++;
            $display("[TB] FAIL sll_latency: got %0d expected 3", done_cycle - accept_cycle);
        end
        checks++;
        if (busy_cnt - busy_base !== 4) begin
            failures++;
            $display("[TB] FAIL sll_busy_cycles: got %0d expected 4", busy_cnt - busy_base);
        end
        checks++;
        if (done_cnt - done_base !== 1) begin
            failures++;
            $display("[TB] FAIL sll_done_pulses: got %0d expected 1", done_cnt - done_base);
        end
    endtask

    task automatic test_srl_sra();
        start_op(32'h0000_00F0, 5'd3, SRL);
        wait_done(40);
        checks++;
        if (done_y !== 32'h0000_001E) begin
            failures++;
            $display("[TB] FAIL srl_y: got %h expected 0000001e", done_y);
        end
        checks++;
        if (done_cycle - accept_cycle !== 3) begin
            failures++;
            $display("[TB] FAIL srl_latency: got %0d expected 3", done_cycle - accept_cycle);
        end
        @(negedge clk);
        start_op(32'h8000_0000, 5'd4, SRA);
        wait_done(40);
        checks++;
        if (done_y !== 32'hF800_0000) begin
            failures++;
            $display("[TB] FAIL sra_y: got %h expected f8000000", done_y);
        end
        checks++;
        if (done_cycle - accept_cycle !== 4) begin
            failures++;
            $display("[TB] FAIL sra_latency: got %0d expected 4", done_cycle - accept_cycle);
        end
        @(negedge clk);
    endtask

    task automatic test_amt_zero();
        start_op(32'hDEAD_BEEF, 5'd0, SLL);
        wait_done(10);
        @(negedge clk);
        checks++;
        if (done_y !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL zero_y: got %h expected deadbeef", done_y);
        end
        checks++;
        if (done_cycle - accept_cycle !== 0) begin
            failures++;
            $display("[TB] FAIL zero_latency: got %0d expected 0", done_cycle - accept_cycle);
        end
        checks++;
        if (busy_cnt - busy_base !== 1) begin
            failures++;
            $display("[TB] FAIL zero_busy_cycles: got %0d expected 1", busy_cnt - busy_base);
        end
    endtask

    task automatic test_ror();
        start_op(32'h0000_001A, 5'd31, ROR);
        wait_done(60);
        @(negedge clk);
        checks++;
        if (done_y !== ROR_EXP) begin
            failures++;
            $display("[TB] FAIL ror_y: got %h expected %h", done_y, ROR_EXP);
        end
        checks++;
        if (done_cycle - accept_cycle !== 31) begin
            failures++;
            $display("[TB] FAIL ror_latency: got %0d expected 31", done_cycle - accept_cycle);
        end
    endtask

    task automatic test_busy_ignore();
        int base;
        start_op(32'h0000_0001, 5'd5, SLL);
        @(negedge clk);
        checks++;
        if (bus.y !== ROR_EXP) begin
            failures++;
            $display("[TB] FAIL busy_y_stable: got %h expected %h", bus.y, ROR_EXP);
        end
        bus.start = 1'b1;
        bus.a = 32'hFFFF_FFFF;
        bus.amt = 5'd1;
        bus.op = SRL;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(40);
        base = done_base;
        checks++;
        if (done_y !== 32'h0000_0020) begin
            failures++;
            $display("[TB] FAIL busy_y: got %h expected 00000020", done_y);
        end
        checks++;
        if (done_cycle - accept_cycle !== 5) begin
            failures++;
            $display("[TB] FAIL busy_latency: got %0d expected 5", done_cycle - accept_cycle);
        end
        bus.start = 1'b1;
        bus.a = 32'h0000_0007;
        bus.amt = 5'd0;
        bus.op = SLL;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_start_ignored: got busy=%b expected 0", bus.busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - base !== 1 || bus.y !== 32'h0000_0020) begin
            failures++;
            $display("[TB] FAIL busy_no_extra_done: got pulses=%0d y=%h expected 1 00000020",
                     done_cnt - base, bus.y);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        start_op(32'h0000_0003, 5'd10, SLL);
        repeat (3) @(negedge clk);
        base = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.y !== 32'h0 || bus.done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: got busy=%b done=%b y=%h expected 0 0 00000000",
                     bus.busy, bus.done, bus.y);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt !== base || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_no_done: got pulses=%0d busy=%b expected 0 0",
                     done_cnt - base, bus.busy);
        end
    endtask

    task automatic test_after_reset();
        start_op(32'h8000_0000, 5'd31, SRL);
        wait_done(60);
        @(negedge clk);
        checks++;
        if (done_y !== 32'h0000_0001) begin
            failures++;
            $display("[TB] FAIL after_reset_y: got %h expected 00000001", done_y);
        end
        checks++;
        if (done_cycle - accept_cycle !== 31) begin
            failures++;
            $display("[TB] FAIL after_reset_latency: got %0d expected 31", done_cycle - accept_cycle);
        end
    endtask

    task automatic test_back_to_back();
        int first_accept;
        start_op(32'h0000_0001, 5'd1, SLL);
        wait_done(20);
        first_accept = accept_cycle;
        checks++;
        if (done_y !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL b2b_first_y: got %h expected 00000002", done_y);
        end
        start_op(32'h0000_0100, 5'd2, SRL);
        checks++;
        if (accept_cycle - first_accept !== 3 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: got %0d busy=%b expected 3 1",
                     accept_cycle - first_accept, bus.busy);
        end
        wait_done(20);
        checks++;
        if (done_y !== 32'h0000_0040) begin
            failures++;
            $display("[TB] FAIL b2b_second_y: got %h expected 00000040", done_y);
        end
        checks++;
        if (done_cycle - accept_cycle !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_latency: got %0d expected 2", done_cycle - accept_cycle);
        end
        @(negedge clk);
    endtask

    // Run every scenario in order, then report
    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.amt = '0;
        bus.op = SLL;
        test_reset();
        test_sll();
        test_srl_sra();
        test_amt_zero();
        test_ror();
        test_busy_ignore();
        test_reset_mid();
        test_after_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
